// File: rtl/ps2_host_tx_if.sv
// Command-side handshake for the PS/2 host transmitter: request/byte in,
// idle/done/ack status out.
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;

    modport master (output wr_ps2, output din,
                    input tx_idle, input tx_done_tick, input ack_err);
    modport slave  (input wr_ps2, input din,
                    output tx_idle, output tx_done_tick, output ack_err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, start, 8 data LSB first,
// odd parity, stop, then samples the device acknowledge.
module ps2_host_tx #(
    parameter int CLK_HOLD   = 5000,
    parameter int FILTER_LEN = 8
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  bus,
    inout  wire           ps2c,
    inout  wire           ps2d
);
    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;

    state_t                state_q, state_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic [1:0]            dsync_q;
    logic [8:0]            data_q, data_d;
    logic [3:0]            n_q, n_d;
    logic [12:0]           cnt_q, cnt_d;
    logic                  ack_err_q, ack_err_d;
    logic                  fall_edge;
    logic                  done;

    // Filtered clock only changes on a full run of identical samples.
    always_comb begin
        filt_d = {ps2c, filt_q[FILTER_LEN-1:1]};
        fclk_d = fclk_q;
        if (&filt_d)
            fclk_d = 1'b1;
        else if (~|filt_d)
            fclk_d = 1'b0;
    end

    assign fall_edge = fclk_q & ~fclk_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            filt_q    <= '1;
            fclk_q    <= 1'b1;
            dsync_q   <= 2'b11;
            data_q    <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            fclk_q    <= fclk_d;
            dsync_q   <= {dsync_q[0], ps2d};
            data_q    <= data_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        ack_err_d = ack_err_q;
        done      = 1'b0;
        unique case (state_q)
            IDLE: if (bus.wr_ps2) begin
                data_d  = {~^bus.din, bus.din};
                cnt_d   = 13'(CLK_HOLD - 1);
                state_d = RTS;
            end
            RTS: begin
                if (cnt_q == '0)
                    state_d = START;
                else
                    cnt_d = cnt_q - 13'd1;
            end
            START: if (fall_edge) begin
                n_d     = 4'd8;
                state_d = DATA;
            end
            // n counts down 8..0 so parity goes out as the ninth bit.
            DATA: if (fall_edge) begin
                data_d = {1'b0, data_q[8:1]};
                if (n_q == '0)
                    state_d = STOP;
                else
                    n_d = n_q - 4'd1;
            end
            STOP: if (fall_edge)
                state_d = ACK;
            ACK: if (fall_edge) begin
                ack_err_d = dsync_q[1];
                done      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Open-drain drive: released lines rely on the bus pull-ups.
    assign ps2c = (state_q == RTS) ? 1'b0 : 1'bz;
    assign ps2d = ((state_q == START) || (state_q == DATA && !data_q[0])) ? 1'b0 : 1'bz;

    assign bus.tx_idle      = (state_q == IDLE);
    assign bus.tx_done_tick = done;
    assign bus.ack_err      = ack_err_q;
endmodule
